// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: bundles every non-clock signal of alu_ctrl.
//   Producer side : in_valid/in_ready handshake carrying funct3, funct7, is_imm, op_a, op_b.
//   ALU side      : alu_op/alu_r1/alu_r2 towards the ALU, alu_res/alu_zero back from it.
//   Writeback side: out_valid/out_ready handshake carrying out_res, out_zero, out_illegal.
// Modports: slave  = the alu_ctrl view.
//           master = the environment view (producer, ALU and consumer together).
`timescale 1ns/1ps
interface alu_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_imm;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_r1;
  logic [31:0] alu_r2;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_zero;
  logic        out_illegal;

  modport slave (
    input  in_valid, funct3, funct7, is_imm, op_a, op_b, alu_res, alu_zero, out_ready,
    output in_ready, alu_op, alu_r1, alu_r2, out_valid, out_res, out_zero, out_illegal
  );

  modport master (
    output in_valid, funct3, funct7, is_imm, op_a, op_b, alu_res, alu_zero, out_ready,
    input  in_ready, alu_op, alu_r1, alu_r2, out_valid, out_res, out_zero, out_illegal
  );
endinterface

// File: rtl/alu_ctrl.sv
// alu_ctrl: execute-stage sequencer in front of a one-cycle registered ALU.
// It decodes RV32I (optionally M) funct3/funct7 into ALU opcodes, drives the ALU,
// post-processes SLT/SLTU, and resolves illegal encodings and DIV corner cases locally.
// Ports:
//   clk   - rising-edge clock shared with the ALU
//   rst_n - asynchronous active-low reset
//   bus   - alu_ctrl_if.slave (producer handshake, ALU drive/return, writeback handshake)
// Optional feature macro: ALU_CTRL_M_EN enables MUL/DIV decode and the DIV bypass.
// Without it, funct7=0000001 is illegal and MUL/DIV opcodes are never driven.
`timescale 1ns/1ps
module alu_ctrl (
  input  logic      clk,
  input  logic      rst_n,
  alu_ctrl_if.slave bus
);

  // ALU opcode encoding
  localparam logic [4:0] OP_ADD     = 5'd0;
  localparam logic [4:0] OP_SUB     = 5'd1;
`ifdef ALU_CTRL_M_EN
  localparam logic [4:0] OP_MUL     = 5'd2;
  localparam logic [4:0] OP_DIV     = 5'd3;
`endif
  localparam logic [4:0] OP_AND     = 5'd4;
  localparam logic [4:0] OP_OR      = 5'd5;
  localparam logic [4:0] OP_XOR     = 5'd6;
  localparam logic [4:0] OP_LSHIFT  = 5'd7;
  localparam logic [4:0] OP_LRSHIFT = 5'd8;
  localparam logic [4:0] OP_ARSHIFT = 5'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_r, state_nx_s;
  logic        in_ready_r, out_valid_r;
  logic [4:0]  alu_op_r;
  logic [31:0] alu_r1_r, alu_r2_r;
  logic [31:0] out_res_r;
  logic        out_zero_r, out_illegal_r;
  logic        slt_r, sltu_r;

  logic [4:0]  dec_op_s;
  logic [31:0] dec_r2_s;
  logic        dec_illegal_s, dec_bypass_s, dec_slt_s, dec_sltu_s;
  logic [31:0] dec_bypass_res_s;
  logic        accept_s;
  logic        sign_diff_s, lt_s;
  logic [31:0] capt_res_s;
  logic        capt_zero_s;

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.alu_op      = alu_op_r;
  assign bus.alu_r1      = alu_r1_r;
  assign bus.alu_r2      = alu_r2_r;
  assign bus.out_res     = out_res_r;
  assign bus.out_zero    = out_zero_r;
  assign bus.out_illegal = out_illegal_r;

  assign accept_s = (state_r == IDLE) && bus.in_valid;

  // Instruction decode: opcode, second operand, illegal and DIV-bypass detection
  always_comb begin
    dec_op_s         = OP_ADD;
    dec_r2_s         = bus.op_b;
    dec_illegal_s    = 1'b0;
    dec_bypass_s     = 1'b0;
    dec_bypass_res_s = 32'd0;
    dec_slt_s        = 1'b0;
    dec_sltu_s       = 1'b0;
    if (!bus.is_imm && (bus.funct7 == 7'b0000001)) begin
`ifdef ALU_CTRL_M_EN
      case (bus.funct3)
        3'b000: dec_op_s = OP_MUL;
        3'b100: begin
          dec_op_s = OP_DIV;
          // Results the ALU cannot produce: divide by zero and signed overflow
          if (bus.op_b == 32'd0) begin
            dec_bypass_s     = 1'b1;
            dec_bypass_res_s = 32'hFFFF_FFFF;
          end else if ((bus.op_a == 32'h8000_0000) && (bus.op_b == 32'hFFFF_FFFF)) begin
            dec_bypass_s     = 1'b1;
            dec_bypass_res_s = 32'h8000_0000;
          end else begin
            dec_bypass_s     = 1'b0;
          end
        end
        default: dec_illegal_s = 1'b1;
      endcase
`else
      dec_illegal_s = 1'b1;
`endif
    end else if (!bus.is_imm && (bus.funct7 != 7'b0000000) && (bus.funct7 != 7'b0100000)) begin
      dec_illegal_s = 1'b1;
    end else begin
      case (bus.funct3)
        3'b000: dec_op_s = (bus.funct7[5] && !bus.is_imm) ? OP_SUB : OP_ADD;
        3'b001: begin
          dec_op_s = OP_LSHIFT;
          dec_r2_s = {27'd0, bus.op_b[4:0]};
        end
        3'b010: begin
          dec_op_s  = OP_SUB;
          dec_slt_s = 1'b1;
        end
        3'b011: begin
          dec_op_s   = OP_SUB;
          dec_sltu_s = 1'b1;
        end
        3'b100: dec_op_s = OP_XOR;
        3'b101: begin
          dec_op_s = bus.funct7[5] ? OP_ARSHIFT : OP_LRSHIFT;
          dec_r2_s = {27'd0, bus.op_b[4:0]};
        end
        3'b110: dec_op_s = OP_OR;
        3'b111: dec_op_s = OP_AND;
        default: dec_illegal_s = 1'b1;
      endcase
    end
  end

  // Next-state logic of the accept/execute/capture/respond sequence
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_nx_s = (dec_illegal_s || dec_bypass_s) ? RESP : EXEC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      EXEC: state_nx_s = CAPT;
      CAPT: state_nx_s = RESP;
      RESP: begin
        if (bus.out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == IDLE);
      out_valid_r <= (state_nx_s == RESP);
    end
  end

  // SLT/SLTU from the ALU difference: operand signs decide when they differ,
  // otherwise the sign of the difference does (no overflow is possible then)
  always_comb begin
    sign_diff_s = alu_r1_r[31] ^ alu_r2_r[31];
    if (slt_r) begin
      lt_s = sign_diff_s ? alu_r1_r[31] : bus.alu_res[31];
    end else begin
      lt_s = sign_diff_s ? alu_r2_r[31] : bus.alu_res[31];
    end
    if (slt_r || sltu_r) begin
      capt_res_s  = {31'd0, lt_s};
      capt_zero_s = !lt_s;
    end else begin
      capt_res_s  = bus.alu_res;
      capt_zero_s = bus.alu_zero;
    end
  end

  // ALU drive registers and held result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_r      <= OP_ADD;
      alu_r1_r      <= 32'd0;
      alu_r2_r      <= 32'd0;
      slt_r         <= 1'b0;
      sltu_r        <= 1'b0;
      out_res_r     <= 32'd0;
      out_zero_r    <= 1'b1;
      out_illegal_r <= 1'b0;
    end else begin
      if (accept_s && !dec_illegal_s && !dec_bypass_s) begin
        alu_op_r <= dec_op_s;
        alu_r1_r <= bus.op_a;
        alu_r2_r <= dec_r2_s;
        slt_r    <= dec_slt_s;
        sltu_r   <= dec_sltu_s;
      end
      // Illegal and bypass results are final at accept; dec_bypass_res_s is 0 when illegal
      if (accept_s && (dec_illegal_s || dec_bypass_s)) begin
        out_res_r     <= dec_bypass_res_s;
        out_zero_r    <= (dec_bypass_res_s == 32'd0);
        out_illegal_r <= dec_illegal_s;
      end
      if (state_r == CAPT) begin
        out_res_r     <= capt_res_s;
        out_zero_r    <= capt_zero_s;
        out_illegal_r <= 1'b0;
      end
    end
  end

endmodule
